imm_extend_pipe: RTL and testbench

- Parametrised, pipelined immediate-extension unit for the MIPS datapath. Successor to the plain 16→32 sign extender.
- Supports several extension modes: sign, zero, LUI, branch-offset shift, and byte load extension.
- Has a registered output and a valid/ready handshake with a 2-entry skid buffer, so it can sit between decode and a pipelined execute stage under backpressure.
- Latency is 1 cycle; throughput is 1 beat/cycle.

---
 rtl/imm_ext_pkg.sv | 19 +
 rtl/imm_ext_core.sv | 34 +++
 rtl/imm_extend_pipe.sv | 77 +++++++
 tb/tb_imm_extend_pipe.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/imm_ext_pkg.sv
// Shared definitions for the immediate-extension pipeline: mode encoding
// and the parameter legality rule used by the top level at elaboration.
package imm_ext_pkg;

    localparam int unsigned MODE_W = 3;

    localparam logic [MODE_W-1:0] MODE_SEXT      = 3'd0;
    localparam logic [MODE_W-1:0] MODE_ZEXT      = 3'd1;
    localparam logic [MODE_W-1:0] MODE_LUI       = 3'd2;
    localparam logic [MODE_W-1:0] MODE_SEXT_SHL2 = 3'd3;
    localparam logic [MODE_W-1:0] MODE_SEXT8     = 3'd4;
    localparam logic [MODE_W-1:0] MODE_ZEXT8     = 3'd5;

    // Byte modes need at least 8 input bits; SEXT_SHL2 needs two spare output bits.
    function automatic bit params_ok(input int in_w, input int out_w);
        return (in_w >= 8) && (out_w >= in_w + 2);
    endfunction

endpackage

// File: rtl/imm_ext_core.sv
// Combinational immediate-extension mode mux.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the caller registers and flow-controls the result.
module imm_ext_core
    import imm_ext_pkg::*;
#(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32
) (
    input  logic [IN_W-1:0]   imm,
    input  logic [MODE_W-1:0] mode,
    output logic [OUT_W-1:0]  data,
    output logic              err
);

    logic [OUT_W-1:0] sext;

    assign sext = {{(OUT_W-IN_W){imm[IN_W-1]}}, imm};

    always_comb begin
        data = '0;
        err  = 1'b0;
        case (mode)
            MODE_SEXT:      data = sext;
            MODE_ZEXT:      data = {{(OUT_W-IN_W){1'b0}}, imm};
            MODE_LUI:       data = {imm, {(OUT_W-IN_W){1'b0}}};
            MODE_SEXT_SHL2: data = sext << 2;
            MODE_SEXT8:     data = {{(OUT_W-8){imm[7]}}, imm[7:0]};
            MODE_ZEXT8:     data = {{(OUT_W-8){1'b0}}, imm[7:0]};
            default:        err  = 1'b1;
        endcase
    end

endmodule

// File: rtl/imm_extend_pipe.sv
// Registered immediate extender with valid/ready handshake and a skid register.
// Latency: 1 cycle from accept to out_valid; 1 beat/cycle throughput.
// Backpressure: skid absorbs one beat when out_ready drops; in_ready is a pure flop output.
module imm_extend_pipe
    import imm_ext_pkg::*;
#(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [IN_W-1:0]   in_imm,
    input  logic [MODE_W-1:0] in_mode,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OUT_W-1:0]  out_data,
    output logic              out_err
);

    if (!params_ok(IN_W, OUT_W)) begin : g_bad_params
        $error("imm_extend_pipe: requires IN_W >= 8 and OUT_W >= IN_W+2");
    end

    logic [OUT_W-1:0] ext_data;
    logic             ext_err;
    logic             skid_valid;
    logic [OUT_W-1:0] skid_data;
    logic             skid_err;
    logic             accept;
    logic             out_free;

    imm_ext_core #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W)
    ) u_core (
        .imm  (in_imm),
        .mode (in_mode),
        .data (ext_data),
        .err  (ext_err)
    );

    // Keeps out_ready off the in_ready path: a full skid alone closes the input.
    assign in_ready = ~skid_valid;
    assign accept   = in_valid & in_ready;
    assign out_free = ~out_valid | out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_err    <= 1'b0;
            skid_valid <= 1'b0;
            skid_data  <= '0;
            skid_err   <= 1'b0;
        end else if (out_free) begin
            if (skid_valid) begin
                out_valid  <= 1'b1;
                out_data   <= skid_data;
                out_err    <= skid_err;
                skid_valid <= 1'b0;
            end else if (accept) begin
                out_valid <= 1'b1;
                out_data  <= ext_data;
                out_err   <= ext_err;
            end else begin
                out_valid <= 1'b0;
            end
        end else if (accept) begin
            skid_valid <= 1'b1;
            skid_data  <= ext_data;
            skid_err   <= ext_err;
        end
    end

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Directed bench for imm_extend_pipe at IN_W=16, OUT_W=32.
module tb_imm_extend_pipe;
    import imm_ext_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_imm = '0;
    logic [2:0]  in_mode = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_data;
    logic        out_err;

    int checks = 0;
    int errors = 0;

    imm_extend_pipe #(.IN_W(16), .OUT_W(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_imm    (in_imm),
        .in_mode   (in_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_err   (out_err)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b1;
        in_imm = 16'h1234;
        step();
        step();
        rst = 1'b0;
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        checks++;
        if (out_data !== 32'h0) begin errors++; $display("FAIL reset_out_data got %h want 00000000", out_data); end
        checks++;
        if (out_err !== 1'b0) begin errors++; $display("FAIL reset_out_err got %b want 0", out_err); end
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    endtask

    task automatic test_modes();
        logic [15:0] imms [11] = '{16'h8001, 16'h8001, 16'h1234, 16'hFFFF, 16'h7FFF,
                                   16'h0080, 16'h12F0, 16'h7F80, 16'hFF7F, 16'h7FFF, 16'hFFFF};
        logic [2:0]  modes[11] = '{MODE_SEXT, MODE_ZEXT, MODE_LUI, MODE_SEXT_SHL2, MODE_SEXT_SHL2,
                                   MODE_SEXT8, MODE_ZEXT8, MODE_SEXT8, MODE_ZEXT8, MODE_SEXT, MODE_LUI};
        logic [31:0] exps [11] = '{32'hFFFF8001, 32'h00008001, 32'h12340000, 32'hFFFFFFFC, 32'h0001FFFC,
                                   32'hFFFFFF80, 32'h000000F0, 32'hFFFFFF80, 32'h0000007F, 32'h00007FFF,
                                   32'hFFFF0000};
        out_ready = 1'b1;
        for (int i = 0; i < 11; i++) begin
            in_valid = 1'b1;
            in_imm   = imms[i];
            in_mode  = modes[i];
            step();
            checks++;
            if (out_valid !== 1'b1 || out_data !== exps[i] || out_err !== 1'b0) begin
                errors++;
                $display("FAIL mode_vec%0d got v=%b d=%h e=%b want v=1 d=%h e=0",
                         i, out_valid, out_data, out_err, exps[i]);
            end
        end
        in_valid = 1'b0;
        step();
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL modes_drain got %b want 0", out_valid); end
    endtask

    task automatic test_illegal();
        logic [2:0]  modes[3] = '{3'd6, 3'd7, MODE_SEXT};
        logic [15:0] imms [3] = '{16'hABCD, 16'hABCD, 16'h0005};
        logic [31:0] exps [3] = '{32'h0, 32'h0, 32'h00000005};
        logic        errs [3] = '{1'b1, 1'b1, 1'b0};
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_imm   = imms[i];
            in_mode  = modes[i];
            step();
            checks++;
            if (out_valid !== 1'b1 || out_data !== exps[i] || out_err !== errs[i]) begin
                errors++;
                $display("FAIL illegal_vec%0d got v=%b d=%h e=%b want v=1 d=%h e=%b",
                         i, out_valid, out_data, out_err, exps[i], errs[i]);
            end
        end
        in_valid = 1'b0;
        step();
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        in_mode   = MODE_SEXT;
        in_valid  = 1'b1;
        in_imm    = 16'h0001;
        step();
        checks++;
        if (in_ready !== 1'b1 || out_data !== 32'h1) begin
            errors++; $display("FAIL bp_first got rdy=%b d=%h want rdy=1 d=00000001", in_ready, out_data);
        end
        in_imm = 16'h0002;
        step();
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_full_in_ready got %b want 0", in_ready); end
        in_imm = 16'h0003;
        for (int c = 0; c < 2; c++) begin
            step();
            checks++;
            if (out_valid !== 1'b1 || out_data !== 32'h1 || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_stall%0d got v=%b d=%h rdy=%b want v=1 d=00000001 rdy=0",
                         c, out_valid, out_data, in_ready);
            end
        end
        out_ready = 1'b1;
        step();
        checks++;
        if (out_valid !== 1'b1 || out_data !== 32'h2) begin
            errors++; $display("FAIL bp_release2 got v=%b d=%h want v=1 d=00000002", out_valid, out_data);
        end
        step();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_data !== 32'h3) begin
            errors++; $display("FAIL bp_release3 got v=%b d=%h want v=1 d=00000003", out_valid, out_data);
        end
        step();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL bp_empty got v=%b rdy=%b want v=0 rdy=1", out_valid, in_ready);
        end
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        in_mode   = MODE_ZEXT;
        in_valid  = 1'b1;
        in_imm    = 16'h00AA;
        step();
        in_imm = 16'h00BB;
        step();
        checks++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
            errors++; $display("FAIL rstmid_full got v=%b rdy=%b want v=1 rdy=0", out_valid, in_ready);
        end
        rst    = 1'b1;
        in_imm = 16'h00CC;
        step();
        rst      = 1'b0;
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL rstmid_after got v=%b rdy=%b want v=0 rdy=1", out_valid, in_ready);
        end
        out_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step();
            checks++;
            if (out_valid !== 1'b0) begin
                errors++; $display("FAIL rstmid_stale%0d got v=%b d=%h want v=0", c, out_valid, out_data);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] imm;
        logic [31:0] exp;
        int          bubbles = 0;
        out_ready = 1'b1;
        for (int i = 0; i < 100; i++) begin
            imm      = 16'($urandom);
            in_valid = 1'b1;
            in_imm   = imm;
            in_mode  = (i % 2 == 0) ? MODE_SEXT : MODE_ZEXT;
            exp      = (i % 2 == 0) ? {{16{imm[15]}}, imm} : {16'h0000, imm};
            step();
            if (out_valid !== 1'b1) bubbles++;
            checks++;
            if (out_data !== exp || out_err !== 1'b0) begin
                errors++;
                $display("FAIL b2b_beat%0d got d=%h e=%b want d=%h e=0", i, out_data, out_err, exp);
            end
        end
        in_valid = 1'b0;
        step();
        checks++;
        if (bubbles !== 0) begin errors++; $display("FAIL b2b_bubbles got %0d want 0", bubbles); end
    endtask

    initial begin
        test_reset();
        test_modes();
        test_illegal();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
